// File: rtl/nios2_oci_dct_pkg.sv
// Shared types and defaults for the OCI debug-trace (DCT) capture monitor.
package nios2_oci_dct_pkg;

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DONE    = 2'd2
  } dct_state_e;

  localparam int DCT_DATA_W = 30;
  localparam int DCT_CNT_W  = 4;
  localparam int DCT_DEPTH  = 16;
  localparam int DCT_OVF_W  = 8;

  // One buffer entry carries {count, word}.
  function automatic int dct_entry_w(input int data_w, input int cnt_w);
    return data_w + cnt_w;
  endfunction

endpackage

// File: rtl/nios2_oci_dct_fifo.sv
// First-word-fall-through capture buffer: storage, wrapping pointers, occupancy.
module nios2_oci_dct_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_ok, rd_ok;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == LW'(0));

  // A full buffer still takes a write when the head leaves in the same cycle.
  assign wr_ok = wr_en & (~full | rd_en);
  assign rd_ok = rd_en & ~empty;

  assign rd_data = mem[rd_ptr];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/nios2_oci_dct_monitor.sv
// DCT capture monitor: CAPTURE/DRAIN/DONE control, drop counter, optional
// count-sequence checker enabled by DCT_MON_SEQ_CHECK_EN.
module nios2_oci_dct_monitor
  import nios2_oci_dct_pkg::*;
#(
  parameter int DATA_W = DCT_DATA_W,
  parameter int CNT_W  = DCT_CNT_W,
  parameter int DEPTH  = DCT_DEPTH,
  parameter int OVF_W  = DCT_OVF_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             dct_buffer,
  input  logic [CNT_W-1:0]              dct_count,
  input  logic                          dct_valid,
  input  logic                          test_ending,
  input  logic                          test_has_ended,
  output logic [CNT_W+DATA_W-1:0]       rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(DEPTH):0]        level,
  output logic [OVF_W-1:0]              overflow_cnt,
  output logic                          done,
  output logic                          seq_error
);

  localparam int EW = dct_entry_w(DATA_W, CNT_W);
  localparam int LW = $clog2(DEPTH) + 1;

  dct_state_e state, state_nxt;
  logic       full, empty;
  logic       cap_en, rd_fire, wr_en, drop;

  // Any stop request in the current cycle already blocks the capture.
  assign cap_en  = (state == ST_CAPTURE) & ~test_ending & ~test_has_ended;
  assign rd_valid = (state != ST_DONE) & ~empty;
  assign rd_fire = rd_valid & rd_ready;
  assign wr_en   = cap_en & dct_valid & (~full | rd_fire);
  assign drop    = cap_en & dct_valid & full & ~rd_fire;

  nios2_oci_dct_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data ({dct_count, dct_buffer}),
    .rd_en   (rd_fire),
    .rd_data (rd_data),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    state_nxt = state;
    if (test_has_ended) begin
      state_nxt = ST_DONE;
    end else begin
      case (state)
        ST_CAPTURE: if (test_ending) state_nxt = ST_DRAIN;
        // Empty on entry, or the last entry leaves this cycle.
        ST_DRAIN:   if (empty || (rd_fire && level == LW'(1))) state_nxt = ST_DONE;
        default:    state_nxt = ST_DONE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_CAPTURE;
      done         <= 1'b0;
      overflow_cnt <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state_nxt == ST_DONE);
      if (drop && overflow_cnt != {OVF_W{1'b1}})
        overflow_cnt <= overflow_cnt + OVF_W'(1);
    end
  end

`ifdef DCT_MON_SEQ_CHECK_EN
  logic [CNT_W-1:0] ref_cnt;
  logic             ref_vld;
  logic             seq_err_q;

  // Only accepted captures advance the reference; drops are invisible here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_cnt   <= '0;
      ref_vld   <= 1'b0;
      seq_err_q <= 1'b0;
    end else if (wr_en) begin
      ref_cnt <= dct_count;
      ref_vld <= 1'b1;
      if (ref_vld && dct_count != ref_cnt + CNT_W'(1)) seq_err_q <= 1'b1;
    end
  end

  assign seq_error = seq_err_q;
`else
  assign seq_error = 1'b0;
`endif

endmodule

// File: tb/tb_nios2_oci_dct_monitor.sv
// Directed bench for the DCT capture monitor with hand-computed expectations.
module tb_nios2_oci_dct_monitor;

  localparam int DATA_W = 30;
  localparam int CNT_W  = 4;
  localparam int DEPTH  = 16;
  localparam int OVF_W  = 3;
  localparam int LW     = 5;
  localparam int EW     = 34;
`ifdef DCT_MON_SEQ_CHECK_EN
  localparam logic SEQ_EXP = 1'b1;
`else
  localparam logic SEQ_EXP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] dct_buffer = '0;
  logic [CNT_W-1:0]  dct_count = '0;
  logic              dct_valid = 1'b0;
  logic              test_ending = 1'b0;
  logic              test_has_ended = 1'b0;
  logic [EW-1:0]     rd_data;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [LW-1:0]     level;
  logic [OVF_W-1:0]  overflow_cnt;
  logic              done;
  logic              seq_error;

  int n_vec = 0;
  int n_err = 0;

  nios2_oci_dct_monitor #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W),
    .DEPTH  (DEPTH),
    .OVF_W  (OVF_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .dct_valid      (dct_valid),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .level          (level),
    .overflow_cnt   (overflow_cnt),
    .done           (done),
    .seq_error      (seq_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input int c, input int d);
    logic [31:0] cv, dv;
    cv = c;
    dv = d;
    return {cv[CNT_W-1:0], dv[DATA_W-1:0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int c, input int d);
    dct_valid  = 1'b1;
    dct_count  = CNT_W'(c);
    dct_buffer = DATA_W'(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nrd;
    tick; tick;
    chk("rst_level", level, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_ovf", overflow_cnt, 0);
    chk("rst_done", done, 0);
    chk("rst_seq", seq_error, 0);
    reset = 1'b0;

    // basic capture with FWFT
    rd_ready = 1'b1;
    put(1, 'h101);
    chk("basic_pre_valid", rd_valid, 0);
    tick;
    chk("basic_v1", rd_valid, 1);
    chk("basic_d1", rd_data, mk(1, 'h101));
    put(2, 'h102); tick;
    chk("basic_d2", rd_data, mk(2, 'h102));
    chk("basic_lvl", level, 1);
    put(3, 'h103); tick;
    chk("basic_d3", rd_data, mk(3, 'h103));
    dct_valid = 1'b0; tick;
    chk("basic_lvl0", level, 0);
    chk("basic_empty", rd_valid, 0);

    // overflow: 20 captures into 16 entries
    rd_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin put(i, 'h2000 + i); tick; end
    dct_valid = 1'b0;
    chk("ovf_level", level, 16);
    chk("ovf_cnt", overflow_cnt, 4);
    chk("ovf_head", rd_data, mk(0, 'h2000));

    // full with simultaneous read
    put(20, 'h2014); rd_ready = 1'b1; tick;
    dct_valid = 1'b0; rd_ready = 1'b0;
    chk("fr_level", level, 16);
    chk("fr_ovf", overflow_cnt, 4);
    chk("fr_head", rd_data, mk(1, 'h2001));

    rd_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk("rb_data", rd_data, (i < 16) ? mk(i, 'h2000 + i) : mk(20, 'h2014));
      tick;
    end
    chk("rb_level", level, 0);
    rd_ready = 1'b0;

    // saturation: 8 more drops on top of 4
    for (int i = 0; i < 24; i++) begin put(i, 'h3000 + i); tick; end
    dct_valid = 1'b0;
    chk("sat_ovf", overflow_cnt, 7);
    chk("sat_level", level, 16);

    // reset between edges
    #2 reset = 1'b1; #1;
    chk("mr_level", level, 0);
    chk("mr_rd_valid", rd_valid, 0);
    chk("mr_ovf", overflow_cnt, 0);
    tick; reset = 1'b0;

    // drain
    for (int i = 0; i < 5; i++) begin put(i, 'h4000 + i); tick; end
    put(5, 'h4005); test_ending = 1'b1; tick;
    test_ending = 1'b0;
    chk("dr_level", level, 5);
    chk("dr_done0", done, 0);
    rd_ready = 1'b1;
    nrd = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (rd_valid) begin
        chk("dr_data", rd_data, mk(nrd, 'h4000 + nrd));
        nrd++;
      end
      tick;
      if (nrd == 5) chk("dr_done_next", done, 1);
    end
    chk("dr_reads", nrd, 5);
    chk("dr_done", done, 1);
    chk("dr_rd_valid", rd_valid, 0);
    tick; tick;
    chk("dn_level", level, 0);
    chk("dn_ovf", overflow_cnt, 0);
    dct_valid = 1'b0; rd_ready = 1'b0;

    // priority: test_has_ended over test_ending and dct_valid
    reset = 1'b1; tick; reset = 1'b0;
    for (int i = 0; i < 3; i++) begin put(i, 'h5000 + i); tick; end
    put(3, 'h5003); test_ending = 1'b1; test_has_ended = 1'b1; tick;
    test_ending = 1'b0; test_has_ended = 1'b0;
    chk("pr_done", done, 1);
    chk("pr_rd_valid", rd_valid, 0);
    chk("pr_level", level, 3);
    rd_ready = 1'b1; tick;
    chk("pr_frozen", level, 3);
    chk("pr_rd_valid2", rd_valid, 0);

    #2 reset = 1'b1; #1;
    chk("rs_done", done, 0);
    chk("rs_level", level, 0);
    chk("rs_rd_valid", rd_valid, 0);
    chk("rs_ovf", overflow_cnt, 0);
    chk("rs_seq", seq_error, 0);
    rd_ready = 1'b0; dct_valid = 1'b0;
    tick; reset = 1'b0;

    // sequence check: 5, 6, 8
    put(5, 'h6005); tick;
    chk("sq_first", seq_error, 0);
    put(6, 'h6006); tick;
    chk("sq_ok", seq_error, 0);
    put(8, 'h6008); tick;
    chk("sq_err", seq_error, SEQ_EXP);
    dct_valid = 1'b0; tick; tick;
    chk("sq_sticky", seq_error, SEQ_EXP);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
